// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sequencer that time-shares one 32-bit ALU
// between two requesters. One operation in flight: IDLE -> EXEC -> RESP.
module alu_share_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_valid_i,
    output logic [1:0]  req_ready_o,
    input  logic [3:0]  req_op0_i,
    input  logic [3:0]  req_op1_i,
    input  logic [31:0] req_a0_i,
    input  logic [31:0] req_a1_i,
    input  logic [31:0] req_b0_i,
    input  logic [31:0] req_b1_i,
    input  logic [4:0]  req_shamt0_i,
    input  logic [4:0]  req_shamt1_i,
    output logic [1:0]  rsp_valid_o,
    input  logic [1:0]  rsp_ready_i,
    output logic [31:0] rsp_data_o,
    output logic        rsp_zero_o,
    output logic [3:0]  alu_operation_o,
    output logic [31:0] alu_a_o,
    output logic [31:0] alu_b_o,
    output logic [4:0]  alu_shamt_o,
    input  logic [31:0] alu_data_i,
    input  logic        alu_zero_i
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e      state_q, state_d;
    logic        last_grant_q;
    logic        owner_q;
    logic [3:0]  op_q;
    logic [31:0] a_q, b_q;
    logic [4:0]  shamt_q;
    logic [31:0] rsp_data_q;
    logic        rsp_zero_q;

    logic        grant;
    logic        accept;

    // Round-robin pick: on a tie, favour the requester that did not win last.
    always_comb begin
        grant = 1'b0;
        if (req_valid_i == 2'b11) begin
            grant = ~last_grant_q;
        end else if (req_valid_i[1]) begin
            grant = 1'b1;
        end
        accept      = (state_q == StIdle) && req_valid_i[grant];
        req_ready_o = 2'b00;
        if (accept) begin
            req_ready_o[grant] = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; EXEC always lasts exactly one cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept) state_d = StExec;
            StExec: state_d = StResp;
            StResp: if (rsp_ready_i[owner_q]) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Operand capture on accept, result capture at the end of EXEC.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            op_q         <= 4'd0;
            a_q          <= 32'd0;
            b_q          <= 32'd0;
            shamt_q      <= 5'd0;
            rsp_data_q   <= 32'd0;
            rsp_zero_q   <= 1'b0;
        end else begin
            if (accept) begin
                last_grant_q <= grant;
                owner_q      <= grant;
                op_q         <= grant ? req_op1_i    : req_op0_i;
                a_q          <= grant ? req_a1_i     : req_a0_i;
                b_q          <= grant ? req_b1_i     : req_b0_i;
                shamt_q      <= grant ? req_shamt1_i : req_shamt0_i;
            end
            if (state_q == StExec) begin
                rsp_data_q <= alu_data_i;
                rsp_zero_q <= alu_zero_i;
            end
        end
    end

    // Outputs: ALU sees operands only during EXEC; response is owner one-hot in RESP.
    always_comb begin
        alu_operation_o = 4'd0;
        alu_a_o         = 32'd0;
        alu_b_o         = 32'd0;
        alu_shamt_o     = 5'd0;
        rsp_valid_o     = 2'b00;
        if (state_q == StExec) begin
            alu_operation_o = op_q;
            alu_a_o         = a_q;
            alu_b_o         = b_q;
            alu_shamt_o     = shamt_q;
        end
        if (state_q == StResp) begin
            rsp_valid_o[owner_q] = 1'b1;
        end
        rsp_data_o = rsp_data_q;
        rsp_zero_o = rsp_zero_q;
    end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Sequencer that time-shares the single 32-bit ALU between two requesters, e.g. the main datapath port and a branch/address-calculation port. Each requester issues an operation over a valid/ready handshake. The block arbitrates round-robin, registers the winning operands onto the ALU inputs for one execute cycle, and captures result and zero flag. It returns them to the owning requester over a second valid/ready handshake. Only one operation is in flight at a time.

## Interface
- `N_REQ`, fixed 2 (not a parameter; requester index is 1 bit).
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `req_valid_i[1:0]`  in  2  request valid, one bit per requester.
- `req_ready_o[1:0]`  out  2  request accepted this cycle when valid&ready.
- `req_op0_i`, `req_op1_i`  in  4 each  ALU operation code.
- `req_a0_i`, `req_a1_i`, `req_b0_i`, `req_b1_i`  in  32 each  operands.
- `req_shamt0_i`, `req_shamt1_i`  in  5 each  shift amount.
- `rsp_valid_o[1:0]`  out  2  response valid for requester k.
- `rsp_ready_i[1:0]`  in  2  requester k consumes response.
- `rsp_data_o`  out  32  result, shared by both requesters; qualified by `rsp_valid_o`.
- `rsp_zero_o`  out  1  zero flag of result.
- `alu_operation_o`  out  4  to ALU `alu_operation_i`.
- `alu_a_o`, `alu_b_o`  out  32  to ALU `a_i`, `b_i`.
- `alu_shamt_o`  out  5  to ALU `shamt`.
- `alu_data_i`  in  32  from ALU `alu_data_o`.
- `alu_zero_i`  in  1  from ALU `zero_o`.

## Operation
- ALU op codes: ADD=0011, ORI=0001, SLL=0010, SUB=0100, SRL=0101, LUI=0110. Any other code passes through unchanged; the ALU returns 0 with zero=1.
- FSM states:
  - IDLE: `req_ready_o` is asserted only for the granted requester, and only if it is valid.
  - EXEC: exactly one cycle.
  - RESP: held until the owner asserts `rsp_ready`.
- IDLE→EXEC on handshake. Operands, op, shamt and owner index are latched into registers.
- EXEC→RESP unconditionally. `alu_data_i`/`alu_zero_i` are captured into the response registers.
- RESP→IDLE when `rsp_ready_i[owner]` is high. The next request is not accepted in the same cycle.
- Arbitration is round-robin on `last_grant`:
  - If both requesters are valid, grant the one ≠ `last_grant`.
  - If only one is valid, grant it.
  - `last_grant` updates on each accepted request.
- ALU outputs are driven from the operand registers in EXEC only. In IDLE/RESP they are `alu_operation_o`=0000 and operands/shamt = 0.
- Response registers and `rsp_data_o`/`rsp_zero_o` hold stable throughout RESP. `rsp_valid_o` is one-hot (owner bit) in RESP, else 00.
- No arithmetic is performed in this block. Widths pass straight through.

## Timing
- Reset values:
  - state=IDLE, `last_grant`=1 (requester 0 wins first tie).
  - `req_ready_o`=00, `rsp_valid_o`=00.
  - `rsp_data_o`=0, `rsp_zero_o`=0.
  - ALU outputs 0.
- Latency: handshake at cycle T, EXEC at T+1, `rsp_valid` at T+2. Minimum 3 cycles per operation; a back-to-back throughput of one op per 3 cycles when `rsp_ready` is held high.
- `req_ready_o` is combinational from state, `req_valid_i` and `last_grant`. Requesters must hold valid and payload stable until ready.
- A requester dropping valid before ready means no transaction; there is no error.
- The non-owner `rsp_ready_i` bit is ignored.
- Reset asserted in any state takes effect at the next edge. The in-flight operation is discarded and no response is issued.

## Test plan
- Single ADD: req0 op=0011, a=5, b=7 → `rsp_valid_o`=01 two cycles after handshake, data=12, zero=0.
- SUB zero flag: req1 op=0100, a=9, b=9 → `rsp_valid_o`=10, data=0, zero=1. ALU op returns to 0000 in the RESP cycle.
- Round-robin: both valid continuously, `rsp_ready`=11, req0 ADD 1+1 and req1 SLL b=1, shamt=4. After reset, grants alternate 0,1,0,1. Responses are 2 and 16.
- Backpressure: req0 LUI b=0x0000ABCD, `rsp_ready_i[0]` low for 5 cycles. Data stays 0xABCD0000 and valid stays high throughout. `req_ready_o` stays 00 even though req1 is valid. Completes when ready rises.
- Reset mid-op: reset asserted during EXEC → next cycle all outputs at reset values, no `rsp_valid`. The next tie grants req0.
- Illegal op 1111, a=3, b=4 → data=0, zero=1 returned normally.
